// File: rtl/game_pkg.sv
// Shared definitions for the game controller slice.
// Holds the game and pipe-handshake state encodings, the last visible pixel
// of the 640x480 frame and the score ceiling.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    PLAY  = 2'd2,
    OVER  = 2'd3
  } game_state_t;

  typedef enum logic [1:0] {
    H_REQ  = 2'd0,
    H_BUSY = 2'd1,
    H_DONE = 2'd2,
    H_REL  = 2'd3
  } hs_state_t;

  localparam logic [9:0] FRAME_LAST_X = 10'd639;
  localparam logic [8:0] FRAME_LAST_Y = 9'd479;
  localparam int unsigned SCORE_MAX   = 99;

endpackage

// File: rtl/game_ctrl_if.sv
// Bundle between the game controller and the pipe/sprite stage.
//   pipefinish  pipe stage idle/done indication
//   addscore    pipe-passed level (may stay high for many cycles)
//   pipe_g      pipe green channel at the current pixel, nonzero = pipe body
//   bird_on     bird sprite covers the current pixel
//   x, y        current scan pixel coordinates
//   resetGame   synchronous reset to the pipe stage
//   updatepipe  pipe-sweep request to the pipe stage
// master: the game controller side; slave: the pipe stage side.
interface game_ctrl_if;
  logic       pipefinish;
  logic       addscore;
  logic [7:0] pipe_g;
  logic       bird_on;
  logic [9:0] x;
  logic [8:0] y;
  logic       resetGame;
  logic       updatepipe;

  modport master (
    input  pipefinish, addscore, pipe_g, bird_on, x, y,
    output resetGame, updatepipe
  );

  modport slave (
    output pipefinish, addscore, pipe_g, bird_on, x, y,
    input  resetGame, updatepipe
  );
endinterface

// File: rtl/game_ctrl_bcd2_counter.sv
// Two-digit saturating BCD counter (00..SCORE_MAX).
//   clk   clock
//   clr   synchronous clear to 00 (wins over inc)
//   inc   add one; ignored once the ceiling is reached
//   tens  BCD tens digit
//   ones  BCD ones digit
module bcd2_counter
  import game_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  localparam logic [3:0] MAX_TENS = 4'(SCORE_MAX / 10);
  localparam logic [3:0] MAX_ONES = 4'(SCORE_MAX % 10);

  logic at_max;
  assign at_max = (tens == MAX_TENS) && (ones == MAX_ONES);

  always_ff @(posedge clk) begin
    if (clr) begin
      tens <= 4'd0;
      ones <= 4'd0;
    end else if (inc && !at_max) begin
      if (ones == 4'd9) begin
        ones <= 4'd0;
        tens <= tens + 4'd1;
      end else begin
        ones <= ones + 4'd1;
      end
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Game controller: sequences IDLE/CLEAR/PLAY/OVER, runs the pipe-sweep
// handshake while playing, detects bird/pipe collisions per frame and keeps
// the BCD score.
//   clk         clock, all logic on posedge
//   reset       synchronous active-high reset
//   start_btn   one-cycle start/restart pulse
//   bus         game_ctrl_if.master (pipe stage handshake, pixel info)
//   score_tens  BCD tens digit of the score
//   score_ones  BCD ones digit of the score
//   game_over   high while in OVER
module game_ctrl
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start_btn,
  game_ctrl_if.master bus,
  output logic [3:0]  score_tens,
  output logic [3:0]  score_ones,
  output logic        game_over
);

  game_state_t state, state_next;
  hs_state_t   hs, hs_next;

  logic hit;
  logic hit_latch;
  logic frame_end;
  logic addscore_p1;
  logic resetgame_r;
  logic updatepipe_c;
  logic score_inc;
  logic score_clr;

  assign frame_end = (bus.x == FRAME_LAST_X) && (bus.y == FRAME_LAST_Y);
  assign hit       = (state == PLAY) && bus.bird_on && (bus.pipe_g != 8'd0);

  // Only a rising edge of the pass level scores, and only while playing;
  // an edge on the PLAY->OVER cycle still counts since state is PLAY then.
  assign score_inc = (state == PLAY) && bus.addscore && !addscore_p1;
  assign score_clr = reset || (state == CLEAR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      hs          <= H_REQ;
      resetgame_r <= 1'b1;
      hit_latch   <= 1'b0;
      addscore_p1 <= 1'b0;
    end else begin
      state       <= state_next;
      hs          <= hs_next;
      // Registered, but aligned with the state it describes.
      resetgame_r <= (state_next == IDLE) || (state_next == CLEAR);
      addscore_p1 <= bus.addscore;
      if ((state == CLEAR) || frame_end) begin
        hit_latch <= 1'b0;
      end else if (hit) begin
        hit_latch <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next   = state;
    hs_next      = hs;
    updatepipe_c = 1'b0;

    case (state)
      IDLE:    if (start_btn) state_next = CLEAR;
      CLEAR:   state_next = PLAY;
      PLAY:    if (frame_end && (hit_latch || hit)) state_next = OVER;
      OVER:    if (start_btn) state_next = CLEAR;
      default: state_next = IDLE;
    endcase

    // The handshake only advances while staying in PLAY; any other case
    // parks it at H_REQ so the next game starts with a fresh request.
    if ((state != PLAY) || (state_next != PLAY)) begin
      hs_next = H_REQ;
    end else begin
      case (hs)
        H_REQ:   if (!bus.pipefinish) hs_next = H_BUSY;
        H_BUSY:  if (bus.pipefinish) hs_next = H_DONE;
        H_DONE:  hs_next = H_REL;
        H_REL:   hs_next = H_REQ;
        default: hs_next = H_REQ;
      endcase
    end

    if ((state == PLAY) && ((hs == H_REQ) || (hs == H_BUSY))) begin
      updatepipe_c = 1'b1;
    end
  end

  assign bus.resetGame  = resetgame_r;
  assign bus.updatepipe = updatepipe_c;
  assign game_over      = (state == OVER);

  bcd2_counter u_score (
    .clk  (clk),
    .clr  (score_clr),
    .inc  (score_inc),
    .tens (score_tens),
    .ones (score_ones)
  );

endmodule

// File: tb/tb_game_ctrl.sv
module tb_game_ctrl;

  logic       clk;
  logic       reset;
  logic       start_btn;
  logic [3:0] score_tens;
  logic [3:0] score_ones;
  logic       game_over;

  game_ctrl_if bus_if ();

  game_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start_btn  (start_btn),
    .bus        (bus_if),
    .score_tens (score_tens),
    .score_ones (score_ones),
    .game_over  (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       start;
    logic       pf;
    logic       add;
    logic       bird;
    logic [7:0] pg;
    logic [9:0] x;
    logic [8:0] y;
    logic       e_rg;
    logic       e_up;
    logic       e_go;
    logic [3:0] e_t;
    logic [3:0] e_o;
  } vec_t;

  localparam int NVEC = 21;
  vec_t tbl [NVEC];

  int n_vec;
  int n_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic rg, input logic up,
                         input logic go, input logic [3:0] t, input logic [3:0] o);
    chk({tag, ".resetGame"},  32'(bus_if.resetGame),  32'(rg));
    chk({tag, ".updatepipe"}, 32'(bus_if.updatepipe), 32'(up));
    chk({tag, ".game_over"},  32'(game_over),         32'(go));
    chk({tag, ".tens"},       32'(score_tens),        32'(t));
    chk({tag, ".ones"},       32'(score_ones),        32'(o));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset             = 1'b0;
    start_btn         = 1'b0;
    bus_if.pipefinish = 1'b1;
    bus_if.addscore   = 1'b0;
    bus_if.bird_on    = 1'b0;
    bus_if.pipe_g     = 8'd0;
    bus_if.x          = 10'd0;
    bus_if.y          = 9'd0;
  endtask

  task automatic go_play();
    idle_inputs();
    reset = 1'b1;
    step();
    reset     = 1'b0;
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    step();
  endtask

  task automatic pulse_add();
    bus_if.addscore = 1'b1;
    step();
    bus_if.addscore = 1'b0;
    step();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    idle_inputs();

    //          rst   st    pf    add   bird  pg      x        y       rg    up    go    t     o
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0,   10'd0,   9'd0,   1'b1, 1'b0, 1'b0, 4'd0, 4'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0,   10'd0,   9'd0,   1'b1, 1'b0, 1'b0, 4'd0, 4'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0,   10'd0,   9'd0,   1'b1, 1'b0, 1'b0, 4'd0, 4'd0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   10'd0,   9'd0,   1'b1, 1'b0, 1'b0, 4'd0, 4'd0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0,   10'd0,   9'd0,   1'b0, 1'b1, 1'b0, 4'd0, 4'd0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   10'd0,   9'd0,   1'b0, 1'b1, 1'b0, 4'd0, 4'd0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   10'd0,   9'd0,   1'b0, 1'b1, 1'b0, 4'd0, 4'd0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   10'd0,   9'd0,   1'b0, 1'b1, 1'b0, 4'd0, 4'd0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0,   10'd0,   9'd0,   1'b0, 1'b0, 1'b0, 4'd0, 4'd0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0,   10'd0,   9'd0,   1'b0, 1'b0, 1'b0, 4'd0, 4'd0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0,   10'd0,   9'd0,   1'b0, 1'b1, 1'b0, 4'd0, 4'd0};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0,   10'd0,   9'd0,   1'b0, 1'b1, 1'b0, 4'd0, 4'd1};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0,   10'd0,   9'd0,   1'b0, 1'b1, 1'b0, 4'd0, 4'd1};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0,   10'd0,   9'd0,   1'b0, 1'b1, 1'b0, 4'd0, 4'd1};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0,   10'd0,   9'd0,   1'b0, 1'b1, 1'b0, 4'd0, 4'd2};
    tbl[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0,   10'd639, 9'd479, 1'b0, 1'b1, 1'b0, 4'd0, 4'd2};
    tbl[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd255, 10'd100, 9'd200, 1'b0, 1'b1, 1'b0, 4'd0, 4'd2};
    tbl[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0,   10'd639, 9'd479, 1'b0, 1'b0, 1'b1, 4'd0, 4'd2};
    tbl[18] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0,   10'd0,   9'd0,   1'b0, 1'b0, 1'b1, 4'd0, 4'd2};
    tbl[19] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   10'd0,   9'd0,   1'b1, 1'b0, 1'b0, 4'd0, 4'd2};
    tbl[20] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0,   10'd0,   9'd0,   1'b0, 1'b1, 1'b0, 4'd0, 4'd0};

    for (int i = 0; i < NVEC; i++) begin
      reset             = tbl[i].rst;
      start_btn         = tbl[i].start;
      bus_if.pipefinish = tbl[i].pf;
      bus_if.addscore   = tbl[i].add;
      bus_if.bird_on    = tbl[i].bird;
      bus_if.pipe_g     = tbl[i].pg;
      bus_if.x          = tbl[i].x;
      bus_if.y          = tbl[i].y;
      step();
      chk_all($sformatf("vec%0d", i), tbl[i].e_rg, tbl[i].e_up, tbl[i].e_go,
              tbl[i].e_t, tbl[i].e_o);
    end

    // Long sweep: busy for 50 cycles, then exactly two idle cycles.
    go_play();
    chk("sweep.start_up", 32'(bus_if.updatepipe), 32'd1);
    bus_if.pipefinish = 1'b0;
    for (int i = 0; i < 50; i++) step();
    chk("sweep.busy_up", 32'(bus_if.updatepipe), 32'd1);
    bus_if.pipefinish = 1'b1;
    step();
    chk("sweep.gap1", 32'(bus_if.updatepipe), 32'd0);
    step();
    chk("sweep.gap2", 32'(bus_if.updatepipe), 32'd0);
    step();
    chk("sweep.again", 32'(bus_if.updatepipe), 32'd1);

    // Long pass levels score once each; BCD carry and saturation.
    for (int k = 0; k < 3; k++) begin
      bus_if.addscore = 1'b1;
      for (int i = 0; i < 1000; i++) step();
      bus_if.addscore = 1'b0;
      step();
    end
    chk("score03.tens", 32'(score_tens), 32'd0);
    chk("score03.ones", 32'(score_ones), 32'd3);
    for (int i = 0; i < 6; i++) pulse_add();
    chk("score09.ones", 32'(score_ones), 32'd9);
    pulse_add();
    chk("score10.tens", 32'(score_tens), 32'd1);
    chk("score10.ones", 32'(score_ones), 32'd0);
    for (int i = 0; i < 89; i++) pulse_add();
    chk("score99.tens", 32'(score_tens), 32'd9);
    chk("score99.ones", 32'(score_ones), 32'd9);
    pulse_add();
    chk("sat99.tens", 32'(score_tens), 32'd9);
    chk("sat99.ones", 32'(score_ones), 32'd9);
    chk("sat99.over", 32'(game_over), 32'd0);

    // Hit only at the frame-end pixel, with a score edge on the same cycle.
    go_play();
    bus_if.bird_on  = 1'b1;
    bus_if.pipe_g   = 8'd1;
    bus_if.x        = 10'd639;
    bus_if.y        = 9'd479;
    bus_if.addscore = 1'b1;
    step();
    idle_inputs();
    chk("lasthit.over", 32'(game_over), 32'd1);
    chk("lasthit.up", 32'(bus_if.updatepipe), 32'd0);
    chk("lasthit.ones", 32'(score_ones), 32'd1);

    // Restart from OVER with score 07.
    go_play();
    for (int i = 0; i < 7; i++) pulse_add();
    bus_if.bird_on = 1'b1;
    bus_if.pipe_g  = 8'd255;
    bus_if.x       = 10'd639;
    bus_if.y       = 9'd479;
    step();
    idle_inputs();
    chk_all("over07", 1'b0, 1'b0, 1'b1, 4'd0, 4'd7);
    step();
    chk_all("over07hold", 1'b0, 1'b0, 1'b1, 4'd0, 4'd7);
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    chk_all("restart.clear", 1'b1, 1'b0, 1'b0, 4'd0, 4'd7);
    step();
    chk_all("restart.play", 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);

    // Reset in the middle of a sweep with a nonzero score and hit latched.
    bus_if.pipefinish = 1'b0;
    step();
    pulse_add();
    bus_if.bird_on = 1'b1;
    bus_if.pipe_g  = 8'd9;
    bus_if.x       = 10'd50;
    bus_if.y       = 9'd60;
    step();
    chk_all("midsweep", 1'b0, 1'b1, 1'b0, 4'd0, 4'd1);
    reset = 1'b1;
    step();
    chk_all("midreset", 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    // Hit latch must have been cleared: frame end without a hit stays put.
    reset             = 1'b0;
    start_btn         = 1'b1;
    bus_if.bird_on    = 1'b0;
    bus_if.pipe_g     = 8'd0;
    bus_if.pipefinish = 1'b1;
    step();
    start_btn = 1'b0;
    step();
    bus_if.x = 10'd639;
    bus_if.y = 9'd479;
    step();
    chk("postreset.noover", 32'(game_over), 32'd0);
    chk("postreset.up", 32'(bus_if.updatepipe), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
